// File: rtl/noc_sched_pkg.sv
// Shared definitions for the PCI <-> NoC scheduler.
//   - packet field offsets (packet layout is {seq, dst_y, dst_x, data}, MSB first)
//   - frame FSM state encoding
//   - rr_next: wrapping increment used for the round-robin destination walk
package noc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    // DATA field always sits at the bottom of the packet.
    localparam int PKT_DATA_LSB = 0;

    // Field widths are the module parameters (DATA_W, X_W, Y_W, SEQ_W).
    function automatic int pkt_dst_x_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int pkt_dst_y_lsb(input int data_w, input int x_w);
        return data_w + x_w;
    endfunction

    function automatic int pkt_seq_lsb(input int data_w, input int x_w, input int y_w);
        return data_w + x_w + y_w;
    endfunction

    // Next coordinate in a 0..size-1 walk; wraps to 0 after size-1.
    function automatic logic [31:0] rr_next(input logic [31:0] cur, input logic [31:0] size);
        return (cur >= size - 32'd1) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/noc_sched_rob.sv
// Reorder buffer for returned NoC packets.
// Tag-indexed storage with one valid bit per slot. Returned packets are written
// at their sequence tag; the head pointer walks tags in order so results leave
// in the order the bytes were injected.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   wr_en/wr_seq/wr_data  ejection write (always accepted)
//   none_outstanding   no tag currently in flight (write is then an error)
//   rd_en              pop the head slot (only when head_vld)
//   head_vld/head_data head slot contents
//   err                sticky: duplicate tag or return with nothing in flight
module noc_sched_rob
    import noc_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEQ_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SEQ_W-1:0]  wr_seq,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              none_outstanding,
    input  logic              rd_en,
    output logic              head_vld,
    output logic [DATA_W-1:0] head_data,
    output logic              err
);

    localparam int DEPTH = 2 ** SEQ_W;

    logic [DEPTH-1:0]  slot_vld;
    logic [DATA_W-1:0] slot_data [DEPTH];
    logic [SEQ_W-1:0]  head;

    // Clear of the popped slot is written before the set so that a write to the
    // slot being popped in the same cycle leaves it valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_vld <= '0;
            head     <= '0;
            err      <= 1'b0;
        end else begin
            if (rd_en) begin
                slot_vld[head] <= 1'b0;
                head           <= head + 1'b1;
            end
            if (wr_en) begin
                slot_vld[wr_seq] <= 1'b1;
                if (slot_vld[wr_seq] || none_outstanding) begin
                    err <= 1'b1;
                end
            end
        end
    end

    // Payload storage is not reset; slot_vld qualifies every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            slot_data[wr_seq] <= wr_data;
        end
    end

    // The head read sees the registered valid bit, so a same-cycle write to the
    // head slot is picked up one cycle later.
    assign head_vld  = slot_vld[head];
    assign head_data = slot_data[head];

endmodule

// File: rtl/noc_pci_scheduler.sv
// PCI byte stream <-> NxN mesh scheduler.
// Forward: each accepted PCI byte becomes one packet {seq, dst_y, dst_x, data},
// destinations walked round-robin (x fastest, then y). Return: packets come back
// out of order and are released to PCI in original order via noc_sched_rob.
// A frame of FRAME_LEN bytes is tracked; o_frame_done pulses once all of it has
// been returned.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   i_valid_pci/i_data_pci/o_ready_pci   PCI byte input
//   o_valid_pci/o_data_pci/i_ready_pci   PCI in-order result output
//   o_noc_valid/o_noc_data/i_noc_ready   NoC injection
//   i_noc_valid/i_noc_data/o_noc_ready   NoC ejection (always ready)
//   o_frame_done                   one-cycle end-of-frame pulse
//   o_err                          sticky protocol error
// Optional build macro NOC_SCHED_PERF_CNT_EN adds saturating stall counters
//   o_stall_in  (input byte waiting on o_ready_pci)
//   o_stall_out (result waiting on i_ready_pci)
module noc_pci_scheduler
    import noc_sched_pkg::*;
#(
    parameter int  X_SIZE    = 4,
    parameter int  Y_SIZE    = 4,
    parameter int  DATA_W    = 8,
    parameter int  SEQ_W     = 4,
    parameter int  FRAME_LEN = 262144,
    localparam int X_W       = $clog2(X_SIZE),
    localparam int Y_W       = $clog2(Y_SIZE),
    localparam int PKT_W     = SEQ_W + Y_W + X_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid_pci,
    input  logic [DATA_W-1:0] i_data_pci,
    output logic              o_ready_pci,
    output logic [DATA_W-1:0] o_data_pci,
    output logic              o_valid_pci,
    input  logic              i_ready_pci,
    output logic              o_noc_valid,
    output logic [PKT_W-1:0]  o_noc_data,
    input  logic              i_noc_ready,
    input  logic              i_noc_valid,
    input  logic [PKT_W-1:0]  i_noc_data,
    output logic              o_noc_ready,
    output logic              o_frame_done,
    output logic              o_err
`ifdef NOC_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       o_stall_in,
    output logic [31:0]       o_stall_out
`endif
);

    localparam int DEPTH     = 2 ** SEQ_W;
    localparam int FCNT_W    = $clog2(FRAME_LEN + 1);
    localparam int DSTX_LSB  = pkt_dst_x_lsb(DATA_W);
    localparam int SEQ_LSB   = pkt_seq_lsb(DATA_W, X_W, Y_W);

    localparam logic [SEQ_W:0]  OUT_MAX    = (SEQ_W + 1)'(DEPTH);
    localparam logic [X_W-1:0]  X_LAST     = X_W'(X_SIZE - 1);
    localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAME_LEN - 1);

    sched_state_e      state, state_nxt;
    logic [FCNT_W-1:0] frame_cnt;
    logic [SEQ_W:0]    outstanding;
    logic [SEQ_W-1:0]  seq_wr;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic              ready_en;

    logic              acc_in;
    logic              out_load;
    logic              drain_ok;

    logic              noc_vld_p1;
    logic [PKT_W-1:0]  noc_pkt_p1;
    logic              pci_vld_p1;
    logic [DATA_W-1:0] pci_data_p1;

    logic              head_vld;
    logic [DATA_W-1:0] head_data;

    // Destination bits of returned packets carry no information here.
    logic              unused_dst;
    assign unused_dst = ^i_noc_data[SEQ_LSB-1:DSTX_LSB];

    // ready_en drops with reset so o_ready_pci reads 0 during reset without
    // routing the reset net into combinational logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    assign o_ready_pci = ready_en && (state != DRAIN) && (outstanding < OUT_MAX)
                         && (!noc_vld_p1 || i_noc_ready);
    assign acc_in      = i_valid_pci && o_ready_pci;
    assign out_load    = head_vld && (!pci_vld_p1 || i_ready_pci);
    assign drain_ok    = (outstanding == '0) && !noc_vld_p1 && (!pci_vld_p1 || i_ready_pci);

    // ---- stage p1: injection register (PCI accept -> packet) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            noc_vld_p1 <= 1'b0;
            noc_pkt_p1 <= '0;
        end else if (acc_in) begin
            noc_vld_p1 <= 1'b1;
            noc_pkt_p1 <= {seq_wr, cur_y, cur_x, i_data_pci};
        end else if (i_noc_ready) begin
            noc_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_wr <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
        end else if (acc_in) begin
            seq_wr <= seq_wr + 1'b1;
            cur_x  <= X_W'(rr_next(32'(cur_x), 32'(X_SIZE)));
            if (cur_x == X_LAST) begin
                cur_y <= Y_W'(rr_next(32'(cur_y), 32'(Y_SIZE)));
            end
        end
    end

    // In flight from PCI accept until the result is loaded into the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else begin
            case ({acc_in, out_load})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    noc_sched_rob #(
        .DATA_W (DATA_W),
        .SEQ_W  (SEQ_W)
    ) u_rob (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (i_noc_valid),
        .wr_seq           (i_noc_data[SEQ_LSB +: SEQ_W]),
        .wr_data          (i_noc_data[PKT_DATA_LSB +: DATA_W]),
        .none_outstanding (outstanding == '0),
        .rd_en            (out_load),
        .head_vld         (head_vld),
        .head_data        (head_data),
        .err              (o_err)
    );

    // ---- stage p1: PCI output register (ROB head -> PCI) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pci_vld_p1  <= 1'b0;
            pci_data_p1 <= '0;
        end else if (out_load) begin
            pci_vld_p1  <= 1'b1;
            pci_data_p1 <= head_data;
        end else if (i_ready_pci) begin
            pci_vld_p1  <= 1'b0;
        end
    end

    assign o_noc_valid = noc_vld_p1;
    assign o_noc_data  = noc_pkt_p1;
    assign o_valid_pci = pci_vld_p1;
    assign o_data_pci  = pci_data_p1;
    assign o_noc_ready = 1'b1;

    // Frame FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Frame FSM: next state. The accept that leaves IDLE is byte 1 of the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc_in) state_nxt = (FRAME_LEN == 1) ? DRAIN : RUN;
            end
            RUN: begin
                if (acc_in && (frame_cnt == FRAME_LAST)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame FSM: outputs
    always_comb begin
        o_frame_done = 1'b0;
        if (state == DRAIN) o_frame_done = drain_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE:    frame_cnt <= acc_in ? FCNT_W'(1) : '0;
                RUN:     if (acc_in) frame_cnt <= frame_cnt + 1'b1;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

`ifdef NOC_SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_stall_in  <= '0;
            o_stall_out <= '0;
        end else begin
            if (i_valid_pci && !o_ready_pci && (o_stall_in != '1)) begin
                o_stall_in <= o_stall_in + 1'b1;
            end
            if (o_valid_pci && !i_ready_pci && (o_stall_out != '1)) begin
                o_stall_out <= o_stall_out + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/noc_pci_scheduler.md
Name: noc_pci_scheduler

Overview:
- Sits between the PCI byte-stream port and the NxN mesh injection/ejection port inside openNocTop.
- Forward path: each accepted PCI byte becomes one NoC packet. Packets go to PEs in round-robin order (x fastest, then y) and carry a sequence tag.
- Return path: processed packets arrive out of order. A reorder buffer releases them to PCI in original byte order.
- Framing: tracks one frame of FRAME_LEN bytes and pulses o_frame_done when the whole frame has been returned.

Parameters:
- X_SIZE, 4, mesh columns.
- Y_SIZE, 4, mesh rows.
- DATA_W, 8, pixel width.
- SEQ_W, 4, tag width; reorder depth and max outstanding = 2**SEQ_W.
- FRAME_LEN, 262144, bytes per frame (512x512 image).
- X_W/Y_W, $clog2(X_SIZE)/$clog2(Y_SIZE), coordinate widths (localparam).
- PKT_W, SEQ_W+Y_W+X_W+DATA_W (localparam).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- i_valid_pci  in  1  PCI byte valid
- i_data_pci  in  DATA_W  PCI byte
- o_ready_pci  out  1  scheduler can accept byte
- o_data_pci  out  DATA_W  in-order result byte
- o_valid_pci  out  1  result valid
- i_ready_pci  in  1  PCI sink ready
- o_noc_valid  out  1  injection valid
- o_noc_data  out  PKT_W  packet {seq, dst_y, dst_x, data}
- i_noc_ready  in  1  injection ready
- i_noc_valid  in  1  ejection valid
- i_noc_data  in  PKT_W  returned packet; only seq and data are used
- o_noc_ready  out  1  tied 1 (a reorder slot is always pre-reserved)
- o_frame_done  out  1  one-cycle pulse at end of frame
- o_err  out  1  sticky: duplicate tag or return while no tag is outstanding

Behaviour:
- Reset (rst=0, async): all outputs 0 except o_noc_ready=1. Pointers, counters and coordinates 0; all ROB valid bits cleared; FSM=IDLE.
- Reset mid-frame: discards all in-flight state. Packets returned after reset are counted as errors (o_err).
- Handshakes: a transfer occurs when valid&ready. Valid is held with data stable until accepted.
- o_ready_pci = (state!=DRAIN) && (outstanding<2**SEQ_W) && (!o_noc_valid || i_noc_ready).
- Injection register: single entry.
  - On PCI accept it loads {seq_wr, cur_y, cur_x, i_data_pci} and sets o_noc_valid=1. Latency: 1 cycle from PCI accept to packet.
  - It clears when accepted by the NoC with no new load.
- Round robin: cur_x increments per accepted byte. It wraps at X_SIZE-1 and increments cur_y at the wrap; cur_y wraps at Y_SIZE-1. seq_wr increments mod 2**SEQ_W.
- Outstanding counter, width SEQ_W+1:
  - +1 on PCI accept, -1 on PCI output load.
  - Both in the same cycle leaves it unchanged.
  - At 2**SEQ_W, o_ready_pci=0 (full).
- Ejection:
  - Writes rob_data[seq]=data and sets rob_vld[seq].
  - If rob_vld[seq] is already set, or outstanding==0, set o_err. Data is still overwritten.
- Output register:
  - Loads rob_data[head] when rob_vld[head] && (!o_valid_pci || i_ready_pci). The same cycle clears rob_vld[head] and increments head mod 2**SEQ_W.
  - Minimum latency: ejection at cycle n gives o_valid_pci at cycle n+2.
  - Ejection write and head read of the same slot in one cycle: the read sees the old (clear) valid bit and waits a cycle.
- FSM:
  - IDLE: frame counter=0. Go to RUN on the first PCI accept, which counts as byte 1.
  - RUN: count accepts. When the FRAME_LEN-th byte is accepted, go to DRAIN.
  - DRAIN: o_ready_pci=0. When outstanding==0, !o_valid_noc and the output register is empty or being accepted, pulse o_frame_done for 1 cycle and return to IDLE.
- Frame counter width: $clog2(FRAME_LEN+1).

Optional Feature:
- Macro: NOC_SCHED_PERF_CNT_EN.
- When defined, adds ports o_stall_in (32, out) and o_stall_out (32, out), both cleared at reset and saturating.
  - o_stall_in counts cycles with i_valid_pci && !o_ready_pci.
  - o_stall_out counts cycles with o_valid_pci && !i_ready_pci.
- When undefined, the ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Package noc_sched_pkg holds:
  - the packet field offsets and widths (SEQ, DST_Y, DST_X, DATA);
  - the FSM state typedef/localparams (IDLE=0, RUN=1, DRAIN=2);
  - the rr_next function for coordinate wrap.
- One sub-module, noc_sched_rob: tag-indexed storage with per-slot valid bits, write port and in-order head read port, plus the err detection.

Test Plan:
- In-order return, X_SIZE=Y_SIZE=2, SEQ_W=2, FRAME_LEN=8:
  - Stimulus: send 0x10..0x17. The NoC model echoes data+1 immediately.
  - Response: destinations (0,0),(1,0),(0,1),(1,1) repeating; o_data_pci 0x11..0x18 in order; one o_frame_done pulse after the 8th output.
- Reverse return:
  - Stimulus: NoC model holds 4 packets (tags 0-3) and returns tags 3,2,1,0.
  - Response: no o_valid_pci until tag 0 arrives; then bytes for tags 0,1,2,3 on 4 consecutive cycles.
- Full/backpressure:
  - Stimulus: hold i_noc_valid returns off; send bytes continuously.
  - Response: o_ready_pci drops after 4 accepts. After one tag-0 return and one PCI read, exactly one more byte is accepted.
- PCI sink stall:
  - Stimulus: i_ready_pci=0 for 10 cycles while results are ready.
  - Response: o_data_pci stable, no loss. With NOC_SCHED_PERF_CNT_EN, o_stall_out=10.
- Error and reset:
  - Stimulus: return tag 1 twice.
  - Response: o_err=1 and stays 1.
  - Stimulus: then assert rst low mid-frame.
  - Response: all outputs 0, o_noc_ready=1, FSM back in IDLE.
